// File: rtl/testbasic6_source.sv
// testbasic6_source: producer for the two blocking input channels of the
// TestBasic6 consumer. Emits a counter value on channel 1 and, once that
// transfer completes, the value plus OFFSET on channel 2. The counter then
// advances by STEP. A pair limit of NUM_PAIRS (0 = unbounded) parks the FSM
// in a terminal DONE state.
// Optional build macro: TB6_SOURCE_IDLE_EN inserts one idle cycle (both
// requests low) between consecutive pairs.
module testbasic6_source #(
   parameter int START     = 4,
   parameter int STEP      = 1,
   parameter int OFFSET    = 100,
   parameter int NUM_PAIRS = 0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] b_out,
   output logic        b_out_notify,
   input  logic        b_out_sync,
   output logic [31:0] b_out2,
   output logic        b_out2_notify,
   input  logic        b_out2_sync,
   output logic        done
);

`ifdef TB6_SOURCE_IDLE_EN
   typedef enum logic [1:0] {
      SEND1 = 2'd0,
      SEND2 = 2'd1,
      DONE  = 2'd2,
      IDLE  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      SEND1 = 2'd0,
      SEND2 = 2'd1,
      DONE  = 2'd2
   } state_t;
`endif

   localparam logic [31:0] START_C     = 32'(START);
   localparam logic [31:0] STEP_C      = 32'(STEP);
   localparam logic [31:0] OFFSET_C    = 32'(OFFSET);
   localparam logic [31:0] NUM_PAIRS_C = 32'(NUM_PAIRS);

   state_t      state_r;
   logic [31:0] cnt_r;
   logic [31:0] pairs_r;

   // Pair sequencer: one transfer per handshake, all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= SEND1;
         cnt_r         <= START_C;
         pairs_r       <= 32'd0;
         b_out         <= START_C;
         b_out_notify  <= 1'b1;
         b_out2        <= 32'd0;
         b_out2_notify <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state_r)
            SEND1: begin
               if (b_out_notify && b_out_sync) begin
                  state_r       <= SEND2;
                  b_out_notify  <= 1'b0;
                  b_out2        <= cnt_r + OFFSET_C;
                  b_out2_notify <= 1'b1;
               end else begin
                  state_r <= SEND1;
               end
            end
            SEND2: begin
               if (b_out2_notify && b_out2_sync) begin
                  cnt_r         <= cnt_r + STEP_C;
                  pairs_r       <= pairs_r + 32'd1;
                  b_out2_notify <= 1'b0;
                  if ((NUM_PAIRS_C != 32'd0) && ((pairs_r + 32'd1) == NUM_PAIRS_C)) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     // Next channel 1 value is loaded now; its request is
                     // raised immediately or after the idle cycle.
                     b_out <= cnt_r + STEP_C;
`ifdef TB6_SOURCE_IDLE_EN
                     state_r <= IDLE;
`else
                     state_r      <= SEND1;
                     b_out_notify <= 1'b1;
`endif
                  end
               end else begin
                  state_r <= SEND2;
               end
            end
`ifdef TB6_SOURCE_IDLE_EN
            IDLE: begin
               state_r      <= SEND1;
               b_out_notify <= 1'b1;
            end
`endif
            DONE: begin
               state_r       <= DONE;
               b_out_notify  <= 1'b0;
               b_out2_notify <= 1'b0;
               done          <= 1'b1;
            end
            default: begin
               state_r       <= DONE;
               b_out_notify  <= 1'b0;
               b_out2_notify <= 1'b0;
               done          <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_testbasic6_source.sv
// Self-checking bench for testbasic6_source. Three instances cover the
// default sequence, a two-pair limit, and signed wrap-around. Expected
// channel values are queued up front; a negedge monitor pops and compares
// them whenever a handshake is about to complete.
module tb_testbasic6_source;

`ifdef TB6_SOURCE_IDLE_EN
   localparam int PER = 3;
`else
   localparam int PER = 2;
`endif
   // Ticks needed for three / two full pairs with both syncs held high.
   localparam int N3 = 3 * PER - (PER - 2);
   localparam int N2 = PER + 2;

   logic clk;
   logic rst;

   logic [31:0] a_out, a_out2, b_out, b_out2, c_out, c_out2;
   logic a_n1, a_n2, a_done, b_n1, b_n2, b_done, c_n1, c_n2, c_done;
   logic a_s1, a_s2, b_s1, b_s2, c_s1, c_s2;

   logic [31:0] q_a1[$], q_a2[$], q_b1[$], q_b2[$], q_c1[$], q_c2[$];

   int n_tests;
   int n_fail;
   int b_x1, b_x2;

   testbasic6_source dut_a (
      .clk(clk), .rst(rst),
      .b_out(a_out), .b_out_notify(a_n1), .b_out_sync(a_s1),
      .b_out2(a_out2), .b_out2_notify(a_n2), .b_out2_sync(a_s2),
      .done(a_done)
   );

   testbasic6_source #(.NUM_PAIRS(2)) dut_b (
      .clk(clk), .rst(rst),
      .b_out(b_out), .b_out_notify(b_n1), .b_out_sync(b_s1),
      .b_out2(b_out2), .b_out2_notify(b_n2), .b_out2_sync(b_s2),
      .done(b_done)
   );

   testbasic6_source #(.START(32'h7FFF_FFFF), .STEP(1), .OFFSET(1)) dut_c (
      .clk(clk), .rst(rst),
      .b_out(c_out), .b_out_notify(c_n1), .b_out_sync(c_s1),
      .b_out2(c_out2), .b_out2_notify(c_n2), .b_out2_sync(c_s2),
      .done(c_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic [31:0] obs, inout logic [31:0] q[$]);
      if (q.size() == 0) check({tag, "_unexpected"}, 32'd1, 32'd0);
      else check(tag, obs, q.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transfer monitor: a handshake visible at negedge completes at the next rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (a_n1 && a_s1) pop_check("a_ch1", a_out, q_a1);
         if (a_n2 && a_s2) pop_check("a_ch2", a_out2, q_a2);
         if (b_n1 && b_s1) begin pop_check("b_ch1", b_out, q_b1); b_x1++; end
         if (b_n2 && b_s2) begin pop_check("b_ch2", b_out2, q_b2); b_x2++; end
         if (c_n1 && c_s1) pop_check("c_ch1", c_out, q_c1);
         if (c_n2 && c_s2) pop_check("c_ch2", c_out2, q_c2);
      end
   end

   initial begin
      bit got;
      n_tests = 0; n_fail = 0; b_x1 = 0; b_x2 = 0;
      rst = 1'b1;
      {a_s1, a_s2, b_s1, b_s2, c_s1, c_s2} = 6'b0;
      tick(); tick();

      // Reset values
      check("rst_a_out", a_out, 32'd4);
      check("rst_a_n1", {31'd0, a_n1}, 32'd1);
      check("rst_a_out2", a_out2, 32'd0);
      check("rst_a_n2", {31'd0, a_n2}, 32'd0);
      check("rst_a_done", {31'd0, a_done}, 32'd0);
      check("rst_c_out", c_out, 32'h7FFF_FFFF);
      rst = 1'b0;

      // Default sequence, both syncs high
      q_a1.push_back(32'd4); q_a1.push_back(32'd5); q_a1.push_back(32'd6);
      q_a2.push_back(32'd104); q_a2.push_back(32'd105); q_a2.push_back(32'd106);
      a_s1 = 1'b1; a_s2 = 1'b1;
      for (int k = 0; k < N3; k++) begin
         check("seq_n1", {31'd0, a_n1}, {31'd0, (k % PER) == 0});
         check("seq_n2", {31'd0, a_n2}, {31'd0, (k % PER) == 1});
         check("seq_done", {31'd0, a_done}, 32'd0);
         tick();
      end
      a_s1 = 1'b0; a_s2 = 1'b0;
      check("seq_q1_empty", q_a1.size(), 32'd0);
      check("seq_q2_empty", q_a2.size(), 32'd0);

      // Two-pair limit
      q_b1.push_back(32'd4); q_b1.push_back(32'd5);
      q_b2.push_back(32'd104); q_b2.push_back(32'd105);
      b_s1 = 1'b1; b_s2 = 1'b1;
      for (int k = 0; k < N2; k++) begin
         check("lim_done_early", {31'd0, b_done}, 32'd0);
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         check("lim_done", {31'd0, b_done}, 32'd1);
         check("lim_n1", {31'd0, b_n1}, 32'd0);
         check("lim_n2", {31'd0, b_n2}, 32'd0);
         tick();
      end
      b_s1 = 1'b0; b_s2 = 1'b0;
      check("lim_x1", b_x1, 32'd2);
      check("lim_x2", b_x2, 32'd2);

      // Reset while channel 2 is requesting
      q_a1.push_back(32'd7);
      a_s1 = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         tick();
         got = a_n2;
      end
      a_s1 = 1'b0;
      check("mid_n2_reached", {31'd0, a_n2}, 32'd1);
      check("mid_out2", a_out2, 32'd107);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out", a_out, 32'd4);
      check("mid_rst_n1", {31'd0, a_n1}, 32'd1);
      check("mid_rst_out2", a_out2, 32'd0);
      check("mid_rst_n2", {31'd0, a_n2}, 32'd0);
      check("mid_rst_b_done", {31'd0, b_done}, 32'd0);
      check("mid_rst_b_n1", {31'd0, b_n1}, 32'd1);
      tick();
      rst = 1'b0;

      // Back-pressure on channel 2 during first pair after reset
      q_a1.push_back(32'd4);
      q_a2.push_back(32'd104);
      a_s1 = 1'b1; a_s2 = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_out2", a_out2, 32'd104);
         check("bp_n2", {31'd0, a_n2}, 32'd1);
         check("bp_n1", {31'd0, a_n1}, 32'd0);
         tick();
      end
      a_s1 = 1'b0; a_s2 = 1'b1;
      tick();
      a_s2 = 1'b0;
      check("bp_after_n2", {31'd0, a_n2}, 32'd0);
`ifndef TB6_SOURCE_IDLE_EN
      check("bp_after_n1", {31'd0, a_n1}, 32'd1);
      check("bp_after_out", a_out, 32'd5);
`else
      check("bp_idle_n1", {31'd0, a_n1}, 32'd0);
`endif
      check("bp_q1_empty", q_a1.size(), 32'd0);
      check("bp_q2_empty", q_a2.size(), 32'd0);

      // Signed wrap-around
      q_c1.push_back(32'h7FFF_FFFF); q_c1.push_back(32'h8000_0000);
      q_c2.push_back(32'h8000_0000); q_c2.push_back(32'h8000_0001);
      c_s1 = 1'b1; c_s2 = 1'b1;
      for (int k = 0; k < N2; k++) tick();
      c_s1 = 1'b0; c_s2 = 1'b0;
      check("wrap_q1_empty", q_c1.size(), 32'd0);
      check("wrap_q2_empty", q_c2.size(), 32'd0);
      check("wrap_done", {31'd0, c_done}, 32'd0);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/testbasic6_source.md
# testbasic6_source

- Producer stage that drives the two blocking input channels of the TestBasic6 consumer.
- Generates a deterministic integer sequence and sends each value as a pair: first on channel 1, then an offset copy on channel 2.
- Uses the team's sync/notify blocking-port handshake.
- Stops after a configurable number of pairs, or runs forever.

## Interface
Parameters:
- START, default 4: first value sent on channel 1; also the reset value of the internal counter.
- STEP, default 1: added to the counter after each completed pair.
- OFFSET, default 100: channel 2 value = counter + OFFSET.
- NUM_PAIRS, default 0: number of pairs to send before stopping; 0 means unbounded.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- b_out, output, 32 (integer): channel 1 data.
- b_out_notify, output, 1: channel 1 write request (data valid).
- b_out_sync, input, 1: channel 1 reader ready.
- b_out2, output, 32 (integer): channel 2 data.
- b_out2_notify, output, 1: channel 2 write request.
- b_out2_sync, input, 1: channel 2 reader ready.
- done, output, 1: high once NUM_PAIRS pairs have completed.

## Operation
- Channel transfer: occurs on a rising edge where notify and sync are both high.
  - sync while notify is low is ignored.
  - Data is held stable while notify is high.
- Internal state:
  - cnt: 32-bit signed counter.
  - pairs: 32-bit count of completed pairs.
  - FSM states: SEND1, SEND2, DONE, plus IDLE when the configuration macro is defined.
- Reset values:
  - State SEND1; cnt = START; pairs = 0.
  - b_out = START, b_out_notify = 1.
  - b_out2 = 0, b_out2_notify = 0.
  - done = 0.
- SEND1, on transfer:
  - Next state SEND2.
  - b_out_notify <= 0, b_out2 <= cnt + OFFSET, b_out2_notify <= 1.
- SEND2, on transfer:
  - cnt <= cnt + STEP; pairs <= pairs + 1; b_out2_notify <= 0.
  - If NUM_PAIRS != 0 and pairs + 1 == NUM_PAIRS: next state DONE, done <= 1.
  - Otherwise: next state SEND1, b_out <= cnt + STEP, b_out_notify <= 1.
- DONE: terminal.
  - Both notifies 0; sync inputs ignored.
  - Leaves DONE only on reset.
- Arithmetic: all additions 32-bit two's complement, wrapping silently (e.g. 0x7FFFFFFF + 1 = 0x80000000).
- Only one channel is ever requesting at a time. Channel 2 is never requested before channel 1 of the same pair completes.

## Timing
- All outputs registered; no combinational path from any sync input to any output.
- Handover between channels: one cycle after the transfer edge, the other channel's notify is high.
- Best-case throughput (both syncs held high, macro undefined): one transfer per cycle, one pair per 2 cycles.
- Back-pressure: a sync low for N cycles stalls the FSM N cycles; the value and notify are unchanged.
- Both syncs high in the same cycle: only the channel whose notify is high transfers.
- Reset asserted mid-pair: asynchronously restores all reset values. A pending channel 2 value is discarded and the sequence restarts at START.

## Configuration
- Macro TB6_SOURCE_IDLE_EN.
- Defined:
  - After each completed pair that does not end in DONE, the FSM spends exactly one cycle in IDLE with both notifies 0.
  - It then enters SEND1 with b_out_notify = 1.
  - Best-case throughput drops to one pair per 3 cycles.
- Undefined: the IDLE state does not exist; SEND2 goes directly to SEND1 as described above.

## Test plan
- Reset, defaults, syncs held high:
  - b_out = 4, 5, 6 on successive SEND1 transfers; b_out2 = 104, 105, 106.
  - Transfers alternate every cycle; done stays 0.
- NUM_PAIRS = 2, syncs held high:
  - Exactly 2 transfers per channel.
  - done = 1 the cycle after the 2nd b_out2 transfer; both notifies then stay 0 for 20 cycles.
- Back-pressure: hold b_out2_sync low 5 cycles during the first pair.
  - b_out2 stays 104 with notify high for all 5 cycles.
  - b_out_notify stays 0.
- Wrap: START = 0x7FFFFFFF, STEP = 1, OFFSET = 1.
  - Pair 1: b_out2 = 0x80000000.
  - Pair 2: b_out = 0x80000000, b_out2 = 0x80000001.
- Assert rst while b_out2_notify = 1:
  - All outputs return to their reset values immediately.
  - The first transfer after release is b_out = START.
- With TB6_SOURCE_IDLE_EN defined, syncs held high:
  - One cycle with both notifies low between pairs; pair period 3 cycles.
